gcd_lcm_coproc: RTL and testbench
=================================

// Module: gcd_lcm_coproc
// PURPOSE
//  Memory-mapped GCD/LCM coprocessor. It sits downstream of the riscvsingle core, on the same
//  store/load path as dmem, selected by a top-level address decode.
//  Software writes operands A/B, writes CTRL to start, polls STATUS or waits for done_irq,
//  then reads RESULT. GCD uses iterative subtractive Euclid; LCM = (A/GCD)*B via a 32-cycle
//  restoring divider and one multiply cycle.
// PARAMETERS
//  WIDTH   32  operand/result width; register interface is WIDTH bits wide
//  DIV_CYC 32  divider iterations; must equal WIDTH
// PORTS
//  clk       in   1      rising-edge clock
//  reset_n   in   1      asynchronous, active-low reset
//  sel       in   1      block selected by top-level address decode
//  we        in   1      write strobe (core MemWrite & sel)
//  addr      in   3      word index: 0 OPA, 1 OPB, 2 CTRL, 3 STATUS, 4 RESULT
//  wdata     in   WIDTH  store data from the core
//  rdata     out  WIDTH  combinational read of the register at addr; 0 if !sel or addr>4
//  busy      out  1      FSM not in IDLE
//  done_irq  out  1      one-cycle pulse when RESULT becomes valid
// BEHAVIOUR
//  Reset (async, reset_n=0): OPA, OPB, RESULT and the working registers = 0; op=0;
//   done=0, ovf=0, busy=0, done_irq=0; FSM = IDLE. Reset mid-operation aborts immediately.
//  Registers:
//   - OPA/OPB: RW; writes are ignored while busy.
//   - CTRL write: bit0 = start, bit1 = op (0 GCD, 1 LCM). A read returns {30'b0, op, 1'b0}.
//   - STATUS: RO {29'b0, ovf, done, busy}.
//   - RESULT: RO.
//  Start: a CTRL write with bit0=1 while IDLE latches a<=OPA, b<=OPB and op; clears done and ovf.
//   A start while busy is ignored with no side effects. Edge with the start write = cycle T.
//  FSM: IDLE -> GCD -> (DIV -> MUL) -> DONE -> IDLE.
//  GCD state, one action per cycle:
//   - a>b: a<=a-b.
//   - b>a: b<=b-a.
//   - a==b: gcd found. op=0 -> DONE with RESULT<=a. op=1 -> DIV with dividend=OPA, divisor=a.
//  Zero operands, detected in the first GCD cycle:
//   - If either is 0, RESULT<=(op ? 0 : a|b) and go to DONE.
//   - gcd(0,0)=0 and lcm(x,0)=0.
//   - No subtraction is performed.
//  DIV: restoring divide, one quotient bit per cycle, exactly DIV_CYC cycles. The remainder is
//   always 0 by construction.
//  MUL: 2*WIDTH product = quotient*OPB. RESULT<=product[WIDTH-1:0];
//   ovf<=|product[2*WIDTH-1:WIDTH].
//  DONE: lasts one cycle. done_irq=1 and STATUS.done is set. Next state is IDLE.
//   done stays 1 until the next accepted start.
//  Latency, with s = number of subtract cycles:
//   - GCD: done observed at T+s+2.
//   - LCM: done observed at T+s+35.
//   - Zero operand: done observed at T+2.
//  Worst-case s is about 2^WIDTH (e.g. gcd(1,0xFFFFFFFF)). This is accepted; there is no timeout.
//  OPA/OPB/RESULT are not modified by the computation except RESULT in GCD/MUL.
//   Reading RESULT while busy returns the previous result.
//  Simultaneous write + read is not possible (single-port). rdata is purely combinational.
// TESTING
//  1. OPA=48, OPB=18, CTRL=1 -> busy at T+1, 4 subtracts, done_irq pulse at T+6, RESULT=6,
//     ovf=0.
//  2. OPA=4, OPB=6, CTRL=3 (LCM) -> done_irq at T+37, RESULT=12, STATUS=0x2.
//  3. OPA=0x80000000, OPB=0xC0000000, CTRL=3 -> RESULT=0x80000000, ovf=1, STATUS=0x6.
//  4. Zero operands:
//     - OPA=0, OPB=9, CTRL=1 -> RESULT=9 at T+2.
//     - Same operands, CTRL=3 -> RESULT=0, ovf=0.
//     - OPA=OPB=0, GCD -> RESULT=0.
//  5. During an LCM run: write OPA=7 and CTRL=1 -> both ignored. Final result matches the
//     original operands; OPA readback is unchanged.
//  6. Assert reset_n=0 mid-DIV -> busy=0, STATUS=0, RESULT=0 at once. After release, a fresh
//     GCD(21,14) gives 7.

Source files
------------

// File: rtl/gcd_lcm_coproc.sv
// Memory-mapped GCD/LCM coprocessor: subtractive Euclid GCD, then LCM = (OPA/gcd)*OPB
// through a restoring divider and a single multiply cycle. DIV_CYC must equal WIDTH.
module gcd_lcm_coproc #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DIV_CYC = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sel,
  input  logic             we,
  input  logic [2:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             done_irq
);

  localparam int unsigned CNT_W  = (DIV_CYC > 1) ? $clog2(DIV_CYC) : 1;
  localparam int unsigned PROD_W = 2 * WIDTH;

  localparam logic [2:0] ADDR_OPA    = 3'd0;
  localparam logic [2:0] ADDR_OPB    = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_RESULT = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GCD,
    S_DIV,
    S_MUL,
    S_DONE
  } state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] opa, opb, result;
  logic [WIDTH-1:0] a, b;
  logic [WIDTH-1:0] quo, rem;
  logic [CNT_W-1:0] cnt;
  logic             op, done, ovf;

  logic             wr_c, start_c, zero_c, equal_c, div_last_c, div_ge_c;
  logic [WIDTH:0]   rem_shift_c, rem_diff_c;
  logic [PROD_W-1:0] prod_c;

  // Bus decode; a start is only accepted from IDLE
  assign wr_c    = sel & we;
  assign start_c = wr_c && (addr == ADDR_CTRL) && wdata[0] && (state == S_IDLE);

  // A zero can only be present on the first GCD cycle: subtracting from nonzero never hits 0
  assign zero_c     = (a == '0) || (b == '0);
  assign equal_c    = (a == b);
  assign div_last_c = (cnt == CNT_W'(DIV_CYC - 1));

  // Restoring divide step; divisor is the gcd held in a
  assign rem_shift_c = {rem, quo[WIDTH-1]};
  assign div_ge_c    = (rem_shift_c >= {1'b0, a});
  assign rem_diff_c  = rem_shift_c - {1'b0, a};

  assign prod_c = PROD_W'(quo) * PROD_W'(opb);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start_c) next_state = S_GCD;
      end
      S_GCD: begin
        if (zero_c) begin
          next_state = S_DONE;
        end else if (equal_c) begin
          next_state = op ? S_DIV : S_DONE;
        end
      end
      S_DIV: begin
        if (div_last_c) next_state = S_MUL;
      end
      S_MUL:   next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Operand registers are software-writable only while idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opa <= '0;
      opb <= '0;
    end else if (wr_c && (state == S_IDLE)) begin
      if (addr == ADDR_OPA) opa <= wdata;
      if (addr == ADDR_OPB) opb <= wdata;
    end
  end

  // Working datapath and result/status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a      <= '0;
      b      <= '0;
      quo    <= '0;
      rem    <= '0;
      cnt    <= '0;
      op     <= 1'b0;
      done   <= 1'b0;
      ovf    <= 1'b0;
      result <= '0;
    end else begin
      if (start_c) begin
        a    <= opa;
        b    <= opb;
        op   <= wdata[1];
        done <= 1'b0;
        ovf  <= 1'b0;
      end
      case (state)
        S_GCD: begin
          if (zero_c) begin
            result <= op ? '0 : (a | b);
          end else if (equal_c) begin
            if (!op) begin
              result <= a;
            end else begin
              quo <= opa;
              rem <= '0;
              cnt <= '0;
            end
          end else if (a > b) begin
            a <= a - b;
          end else begin
            b <= b - a;
          end
        end
        S_DIV: begin
          quo <= {quo[WIDTH-2:0], div_ge_c};
          rem <= div_ge_c ? rem_diff_c[WIDTH-1:0] : rem_shift_c[WIDTH-1:0];
          cnt <= cnt + CNT_W'(1);
        end
        S_MUL: begin
          result <= prod_c[WIDTH-1:0];
          ovf    <= |prod_c[PROD_W-1:WIDTH];
        end
        default: ;
      endcase
      if (next_state == S_DONE) done <= 1'b1;
    end
  end

  // busy/done_irq registered from the next state so they track the state register exactly
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy     <= 1'b0;
      done_irq <= 1'b0;
    end else begin
      busy     <= (next_state != S_IDLE);
      done_irq <= (next_state == S_DONE);
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr)
        ADDR_OPA:    rdata = opa;
        ADDR_OPB:    rdata = opb;
        ADDR_CTRL:   rdata = WIDTH'({op, 1'b0});
        ADDR_STATUS: rdata = WIDTH'({ovf, done, busy});
        ADDR_RESULT: rdata = result;
        default:     rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_lcm_coproc.sv
// Bench for gcd_lcm_coproc: Euclid-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized operand runs.
module tb_gcd_lcm_coproc;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          reset_n, sel, we;
  logic [2:0]    addr;
  logic [W-1:0]  wdata, rdata;
  logic          busy, done_irq;

  always #5 clk = ~clk;

  gcd_lcm_coproc #(.WIDTH(W), .DIV_CYC(W)) dut (
    .clk(clk), .reset_n(reset_n), .sel(sel), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .busy(busy), .done_irq(done_irq)
  );

  int checks = 0;
  int passes = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic logic [W-1:0] gcd_of(input logic [W-1:0] x0, input logic [W-1:0] y0);
    logic [W-1:0] x, y, t;
    x = x0; y = y0;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  // Subtractive steps = sum of Euclid quotients, minus the last one that would reach zero
  function automatic longint sub_steps(input logic [W-1:0] x0, input logic [W-1:0] y0);
    logic [W-1:0] x, y, t;
    longint s;
    x = x0; y = y0; s = 0;
    while (y != 0) begin
      s += longint'(x / y);
      t = x % y; x = y; y = t;
    end
    return s - 1;
  endfunction

  function automatic int f_lat(input logic op, input logic [W-1:0] x, input logic [W-1:0] y);
    if (x == 0 || y == 0) return 2;
    return int'(sub_steps(x, y)) + (op ? 35 : 2);
  endfunction

  function automatic logic [63:0] f_lcm64(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] q;
    q = 64'(x / gcd_of(x, y));
    return q * 64'(y);
  endfunction

  function automatic logic [W-1:0] f_res(input logic op, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] l;
    if (x == 0 || y == 0) return op ? '0 : (x | y);
    if (!op) return gcd_of(x, y);
    l = f_lcm64(x, y);
    return l[W-1:0];
  endfunction

  function automatic logic f_ovf(input logic op, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] l;
    if (x == 0 || y == 0 || !op) return 1'b0;
    l = f_lcm64(x, y);
    return |l[63:W];
  endfunction

  logic [W-1:0] m_opa = '0, m_opb = '0, m_res = '0, p_res = '0;
  logic         m_op = 1'b0, m_done = 1'b0, m_ovf = 1'b0, p_ovf = 1'b0;
  int           m_rem = 0;  // cycles left until the coprocessor is idle again

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_opa <= '0; m_opb <= '0; m_res <= '0; m_op <= 1'b0;
      m_done <= 1'b0; m_ovf <= 1'b0; m_rem <= 0;
    end else begin
      if (m_rem > 0) m_rem <= m_rem - 1;
      if (m_rem == 2) begin
        m_res <= p_res; m_ovf <= p_ovf; m_done <= 1'b1;
      end
      if (sel && we && m_rem == 0) begin
        case (addr)
          3'd0: m_opa <= wdata;
          3'd1: m_opb <= wdata;
          3'd2: if (wdata[0]) begin
            m_op   <= wdata[1];
            m_done <= 1'b0;
            m_ovf  <= 1'b0;
            m_rem  <= f_lat(wdata[1], m_opa, m_opb);
            p_res  <= f_res(wdata[1], m_opa, m_opb);
            p_ovf  <= f_ovf(wdata[1], m_opa, m_opb);
          end
          default: ;
        endcase
      end
    end
  end

  function automatic logic [W-1:0] exp_rdata();
    if (!sel) return '0;
    case (addr)
      3'd0:    return m_opa;
      3'd1:    return m_opb;
      3'd2:    return W'({m_op, 1'b0});
      3'd3:    return W'({m_ovf, m_done, (m_rem > 0)});
      3'd4:    return m_res;
      default: return '0;
    endcase
  endfunction

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (check_en) begin
      chk("busy", 64'(busy), 64'(m_rem > 0));
      chk("done_irq", 64'(done_irq), 64'(m_rem == 1));
      chk("rdata", 64'(rdata), 64'(exp_rdata()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    we = 1'b0; addr = 3'd3; wdata = '0;
  endtask

  task automatic rd_lit(input logic [2:0] a, input logic [W-1:0] exp, input string name);
    sel = 1'b1; we = 1'b0; addr = a;
    #1;
    chk(name, 64'(rdata), 64'(exp));
    @(posedge clk); #1;
  endtask

  // first = cycle index of the next negedge relative to the start edge T
  task automatic wait_irq(input int first, output int obs);
    obs = -1;
    for (int j = first; j < first + 2000; j++) begin
      @(negedge clk);
      if (done_irq) begin obs = j; break; end
      @(posedge clk);
    end
    if (obs < 0) chk("irq_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic run(input logic op, output int obs);
    wr(3'd2, W'({op, 1'b1}));
    wait_irq(1, obs);
  endtask

  task automatic run_model(input logic op, input logic [W-1:0] x, input logic [W-1:0] y);
    int obs;
    wr(3'd0, x); wr(3'd1, y);
    run(op, obs);
    chk("latency", 64'(obs), 64'(f_lat(op, x, y)));
  endtask

  initial begin
    int obs;
    logic [W-1:0] x, y, g;
    logic op;
    sel = 1'b0; we = 1'b0; addr = '0; wdata = '0; reset_n = 1'b0;
    @(posedge clk); #1;
    check_en = 1'b1;
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_irq", 64'(done_irq), 64'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    rd_lit(3'd4, '0, "reset_result");
    rd_lit(3'd3, '0, "reset_status");

    // gcd(48,18): four subtracts
    wr(3'd0, 32'd48); wr(3'd1, 32'd18);
    run(1'b0, obs);
    chk("gcd48_18_lat", 64'(obs), 64'd6);
    rd_lit(3'd4, 32'd6, "gcd48_18_res");
    rd_lit(3'd3, 32'h2, "gcd48_18_status");

    // lcm(4,6)
    wr(3'd0, 32'd4); wr(3'd1, 32'd6);
    run(1'b1, obs);
    chk("lcm4_6_lat", 64'(obs), 64'd37);
    rd_lit(3'd4, 32'd12, "lcm4_6_res");
    rd_lit(3'd3, 32'h2, "lcm4_6_status");
    rd_lit(3'd2, 32'h2, "lcm_ctrl_rd");

    // lcm overflow
    wr(3'd0, 32'h8000_0000); wr(3'd1, 32'hC000_0000);
    run(1'b1, obs);
    rd_lit(3'd4, 32'h8000_0000, "lcm_ovf_res");
    rd_lit(3'd3, 32'h6, "lcm_ovf_status");

    // zero operands
    wr(3'd0, 32'd0); wr(3'd1, 32'd9);
    run(1'b0, obs);
    chk("zero_gcd_lat", 64'(obs), 64'd2);
    rd_lit(3'd4, 32'd9, "zero_gcd_res");
    run(1'b1, obs);
    rd_lit(3'd4, 32'd0, "zero_lcm_res");
    rd_lit(3'd3, 32'h2, "zero_lcm_status");
    wr(3'd1, 32'd0);
    run(1'b0, obs);
    rd_lit(3'd4, 32'd0, "zero_zero_res");

    // writes during a run are ignored
    wr(3'd0, 32'd48); wr(3'd1, 32'd18);
    wr(3'd2, 32'd3);
    wr(3'd0, 32'd7);
    wr(3'd2, 32'd1);
    wait_irq(3, obs);
    chk("busy_wr_lat", 64'(obs), 64'd39);
    rd_lit(3'd4, 32'd144, "busy_wr_res");
    rd_lit(3'd0, 32'd48, "busy_wr_opa");
    rd_lit(3'd2, 32'h2, "busy_wr_ctrl");

    // reset in the middle of the divide
    wr(3'd2, 32'd3);
    repeat (12) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    addr = 3'd3; #1;
    chk("midrst_status", 64'(rdata), 64'(0));
    addr = 3'd4; #1;
    chk("midrst_result", 64'(rdata), 64'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    wr(3'd0, 32'd21); wr(3'd1, 32'd14);
    run(1'b0, obs);
    chk("gcd21_14_lat", 64'(obs), 64'd4);
    rd_lit(3'd4, 32'd7, "gcd21_14_res");

    // randomized runs
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0: begin x = $urandom_range(0, 1) ? 32'd0 : $urandom; y = $urandom_range(0, 1) ? 32'd0 : $urandom; end
        1, 2, 3, 4: begin x = $urandom_range(1, 300); y = $urandom_range(1, 300); end
        5, 6, 7: begin
          g = $urandom_range(1, 32'h00FF_FFFF);
          x = g * $urandom_range(1, 200); y = g * $urandom_range(1, 200);
        end
        default: begin
          g = $urandom_range(32'h1000_0000, 32'h7FFF_FFFF);
          x = g * $urandom_range(1, 2); y = g * $urandom_range(1, 2);
        end
      endcase
      op = 1'($urandom_range(0, 1));
      run_model(op, x, y);
      repeat ($urandom_range(1, 3)) begin
        sel = 1'($urandom_range(0, 1)); we = 1'b0; addr = 3'($urandom_range(0, 7));
        @(posedge clk); #1;
      end
    end

    @(negedge clk);
    check_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
